// File: rtl/tia_playfield_scanner.sv
// Playfield scan-out: holds PF0/PF1/PF2/CTRLPF and serialises the 20-bit playfield
// token across the visible line, one pixel per color clock, with optional mirroring.
module tia_playfield_scanner #(
    parameter int unsigned HBLANK_CLKS = 68,
    parameter int unsigned BIT_CLKS    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cce,
    input  logic       line_start,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       pf,
    output logic       visible,
    output logic       right_half
);

    localparam int unsigned CNT_W   = (HBLANK_CLKS > 1) ? $clog2(HBLANK_CLKS) : 1;
    localparam int unsigned SUB_W   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned PF_BITS = 20;
    localparam int unsigned TOK_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HBLANK = 2'd1,
        LEFT   = 2'd2,
        RIGHT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             pf_d, visible_d, right_half_d;

    logic [3:0]       pf0_q;
    logic [7:0]       pf1_q;
    logic [7:0]       pf2_q;
    logic             reflect_q;

    logic [TOK_W-1:0] token;
    logic [BIT_W-1:0] idx;

    // CPU-visible registers; writes land regardless of cce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf0_q     <= '0;
            pf1_q     <= '0;
            pf2_q     <= '0;
            reflect_q <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0:    pf0_q     <= wr_data[7:4];
                2'd1:    pf1_q     <= wr_data;
                2'd2:    pf2_q     <= wr_data;
                default: reflect_q <= wr_data[0];
            endcase
        end
    end

    // Token in scan order: PF0[4..7], PF1[7..0], PF2[0..7]; upper bits pad to a power of two
    always_comb begin
        token = '0;
        for (int i = 0; i < 4; i++) token[i]      = pf0_q[i];
        for (int i = 0; i < 8; i++) token[4 + i]  = pf1_q[7 - i];
        for (int i = 0; i < 8; i++) token[12 + i] = pf2_q[i];
    end

    assign idx = (state_q == RIGHT && reflect_q) ? BIT_W'(PF_BITS - 1) - bit_q : bit_q;

    // State register, scan counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sub_q      <= '0;
            pf         <= 1'b0;
            visible    <= 1'b0;
            right_half <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sub_q      <= sub_d;
            pf         <= pf_d;
            visible    <= visible_d;
            right_half <= right_half_d;
        end
    end

    // Next-state: line_start restarts blanking from any state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sub_d   = sub_q;
        if (cce) begin
            if (line_start) begin
                state_d = HBLANK;
                cnt_d   = '0;
                bit_d   = '0;
                sub_d   = '0;
            end else begin
                case (state_q)
                    HBLANK: begin
                        if (cnt_q == CNT_W'(HBLANK_CLKS - 1)) begin
                            state_d = LEFT;
                            cnt_d   = '0;
                            bit_d   = '0;
                            sub_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    LEFT, RIGHT: begin
                        if (sub_q == SUB_W'(BIT_CLKS - 1)) begin
                            sub_d = '0;
                            if (bit_q == BIT_W'(PF_BITS - 1)) begin
                                bit_d   = '0;
                                state_d = (state_q == LEFT) ? RIGHT : IDLE;
                            end else begin
                                bit_d = bit_q + BIT_W'(1);
                            end
                        end else begin
                            sub_d = sub_q + SUB_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output sample reflects the state before this edge's transition
    always_comb begin
        pf_d         = pf;
        visible_d    = visible;
        right_half_d = right_half;
        if (cce) begin
            if (state_q == LEFT || state_q == RIGHT) begin
                pf_d         = token[idx];
                visible_d    = 1'b1;
                right_half_d = (state_q == RIGHT);
            end else begin
                pf_d         = 1'b0;
                visible_d    = 1'b0;
                right_half_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tia_playfield_scanner.sv
// Scoreboard bench for tia_playfield_scanner: a line-position model pushes the
// expected {pf,visible,right_half} for every clock, popped one clock later.
module tb_tia_playfield_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cce;
    logic       line_start;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       pf;
    logic       visible;
    logic       right_half;

    tia_playfield_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cce        (cce),
        .line_start (line_start),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pf         (pf),
        .visible    (visible),
        .right_half (right_half)
    );

    always #5 clk = ~clk;

    logic [2:0] q[$];
    logic [2:0] cur;
    logic [3:0] m_pf0;
    logic [7:0] m_pf1;
    logic [7:0] m_pf2;
    logic       m_refl;
    int         pos;
    int         checks = 0;
    int         passed = 0;

    // Playfield bit for scan index 0..19 from the model registers
    function automatic logic model_bit(input int i);
        logic [3:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        p0 = m_pf0;
        p1 = m_pf1;
        p2 = m_pf2;
        if (i < 4)       return p0[i];
        else if (i < 12) return p1[11 - i];
        else             return p2[i - 12];
    endfunction

    // pos = cce edges since the line_start edge (-1 when idle); pixel k is visible for k in 69..228
    task automatic tick(input logic c, input logic ls, input logic we,
                        input logic [1:0] a, input logic [7:0] d);
        int k, v, b, i;
        cce = c; line_start = ls; wr_en = we; wr_addr = a; wr_data = d;
        if (!rst_n) begin
            cur = '0; pos = -1;
            m_pf0 = '0; m_pf1 = '0; m_pf2 = '0; m_refl = 1'b0;
        end else begin
            if (c) begin
                k = (pos >= 0) ? pos + 1 : -1;
                if (k >= 69 && k <= 228) begin
                    v = k - 69;
                    b = (v % 80) / 4;
                    i = (v >= 80 && m_refl) ? 19 - b : b;
                    cur = {model_bit(i), 1'b1, (v >= 80) ? 1'b1 : 1'b0};
                end else begin
                    cur = '0;
                end
                if (ls)                     pos = 0;
                else if (k >= 0 && k < 228) pos = k;
                else                        pos = -1;
            end
            if (we) begin
                case (a)
                    2'd0:    m_pf0  = d[7:4];
                    2'd1:    m_pf1  = d;
                    2'd2:    m_pf2  = d;
                    default: m_refl = d[0];
                endcase
            end
        end
        q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cce = 1'b0; line_start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cur = '0; pos = -1; m_pf0 = '0; m_pf1 = '0; m_pf2 = '0; m_refl = 1'b0;
        #2;
        checks++;
        if ({pf, visible, right_half} !== 3'b000)
            $display("FAIL reset_outputs got=%b exp=000", {pf, visible, right_half});
        else passed++;
        tick(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        void'(q.pop_front());
        checks++;
        if ({pf, visible, right_half} !== 3'b000)
            $display("FAIL reset_held got=%b exp=000", {pf, visible, right_half});
        else passed++;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
            checks++;
            if (q.size() == 0) $display("FAIL reset_idle scoreboard empty");
            else begin
                cur = q.pop_front();
                if ({pf, visible, right_half} !== cur)
                    $display("FAIL reset_idle n=%0d got=%b exp=%b", n, {pf, visible, right_half}, cur);
                else passed++;
            end
        end
    endtask

    // One full line with the given writes already applied; also counts pf and visible highs
    task automatic test_line(input string name, input int exp_ones);
        logic [2:0] e;
        int ones, vis, first_vis;
        ones = 0; vis = 0; first_vis = -1;
        for (int k = 0; k <= 230; k++) begin
            tick(1'b1, k == 0, 1'b0, 2'd0, 8'h00);
            checks++;
            if (q.size() == 0) $display("FAIL %s scoreboard empty", name);
            else begin
                e = q.pop_front();
                if ({pf, visible, right_half} !== e)
                    $display("FAIL %s k=%0d got=%b exp=%b", name, k, {pf, visible, right_half}, e);
                else passed++;
            end
            if (pf === 1'b1) ones++;
            if (visible === 1'b1) begin
                vis++;
                if (first_vis < 0) first_vis = k;
            end
        end
        checks++;
        if (ones !== exp_ones) $display("FAIL %s_ones got=%0d exp=%0d", name, ones, exp_ones);
        else passed++;
        checks++;
        if (vis !== 160 || first_vis !== 69)
            $display("FAIL %s_visible got=%0d@%0d exp=160@69", name, vis, first_vis);
        else passed++;
    endtask

    task automatic write_idle(input logic [1:0] a, input logic [7:0] d);
        tick(1'b0, 1'b0, 1'b1, a, d);
        void'(q.pop_front());
    endtask

    task automatic test_blank_line;
        test_line("blank", 0);
    endtask

    task automatic test_pf0;
        write_idle(2'd0, 8'h10);
        test_line("pf0", 8);
    endtask

    task automatic test_reflect;
        write_idle(2'd0, 8'h00);
        write_idle(2'd2, 8'h80);
        write_idle(2'd3, 8'h01);
        test_line("reflect", 8);
    endtask

    task automatic test_pf1;
        write_idle(2'd2, 8'h00);
        write_idle(2'd3, 8'h00);
        write_idle(2'd1, 8'hAA);
        test_line("pf1", 32);
    endtask

    task automatic test_cce_half;
        logic [2:0] e;
        int ones;
        ones = 0;
        for (int n = 0; n < 470; n++) begin
            tick((n % 2) == 0, n == 0, 1'b0, 2'd0, 8'h00);
            checks++;
            if (q.size() == 0) $display("FAIL cce_half scoreboard empty");
            else begin
                e = q.pop_front();
                if ({pf, visible, right_half} !== e)
                    $display("FAIL cce_half n=%0d got=%b exp=%b", n, {pf, visible, right_half}, e);
                else passed++;
            end
            if (pf === 1'b1) ones++;
        end
        checks++;
        if (ones !== 64) $display("FAIL cce_half_ones got=%0d exp=64", ones);
        else passed++;
    endtask

    // Same-clock write vs sample, live reflect flip, and line_start abort mid-line
    task automatic test_back_to_back;
        logic [2:0] e;
        write_idle(2'd1, 8'h00);
        write_idle(2'd0, 8'h10);
        write_idle(2'd2, 8'h01);
        for (int k = 0; k <= 440; k++) begin
            if (k == 69)       tick(1'b1, 1'b0, 1'b1, 2'd0, 8'h80);
            else if (k == 150) tick(1'b1, 1'b0, 1'b1, 2'd3, 8'h01);
            else               tick(1'b1, (k == 0) || (k == 200), 1'b0, 2'd0, 8'h00);
            checks++;
            if (q.size() == 0) $display("FAIL back_to_back scoreboard empty");
            else begin
                e = q.pop_front();
                if ({pf, visible, right_half} !== e)
                    $display("FAIL back_to_back k=%0d got=%b exp=%b", k, {pf, visible, right_half}, e);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midline;
        logic [2:0] e;
        write_idle(2'd3, 8'h00);
        write_idle(2'd2, 8'hFF);
        for (int k = 0; k <= 109; k++) begin
            tick(1'b1, k == 0, 1'b0, 2'd0, 8'h00);
            void'(q.pop_front());
        end
        checks++;
        if ({pf, visible} !== 2'b01)
            $display("FAIL pre_reset_visible got=%b exp=01", {pf, visible});
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pf, visible, right_half} !== 3'b000)
            $display("FAIL async_reset got=%b exp=000", {pf, visible, right_half});
        else passed++;
        tick(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        void'(q.pop_front());
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
            checks++;
            if (q.size() == 0) $display("FAIL post_reset scoreboard empty");
            else begin
                e = q.pop_front();
                if ({pf, visible, right_half} !== e)
                    $display("FAIL post_reset n=%0d got=%b exp=%b", n, {pf, visible, right_half}, e);
                else passed++;
            end
        end
        write_idle(2'd0, 8'h10);
        test_line("after_reset", 8);
    endtask

    initial begin
        test_reset();
        test_blank_line();
        test_pf0();
        test_reflect();
        test_pf1();
        test_cce_half();
        test_back_to_back();
        test_reset_midline();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
